// File: rtl/sum4_rr_sched.sv
// Round-robin front end that shares one sequential 4-operand sum engine among NREQ clients.
// Optional watchdog on the engine wait, enabled with `define SCHED_TIMEOUT_EN.
module sum4_rr_sched #(
  parameter int WIDTH   = 4,
  parameter int NREQ    = 3,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_b,
  input  logic [NREQ*WIDTH-1:0] op_c,
  input  logic [NREQ*WIDTH-1:0] op_d,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH+1:0]      res,
  output logic [IDW-1:0]        res_id,
  output logic                  res_valid,
  output logic                  err,
  output logic                  eng_start,
  output logic [WIDTH-1:0]      eng_a,
  output logic [WIDTH-1:0]      eng_b,
  output logic [WIDTH-1:0]      eng_c,
  output logic [WIDTH-1:0]      eng_d,
  input  logic [WIDTH+1:0]      eng_f,
  input  logic                  eng_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d, id_q, id_d, res_id_q, res_id_d;
  logic [WIDTH-1:0] eng_a_q, eng_a_d, eng_b_q, eng_b_d, eng_c_q, eng_c_d, eng_d_q, eng_d_d;
  logic [WIDTH+1:0] res_q, res_d;
  logic             res_valid_q, res_valid_d, err_q, err_d;

  logic             found;
  logic [IDW-1:0]   win, ptr_nxt;
  logic [WIDTH-1:0] sel_a, sel_b, sel_c, sel_d;
  logic             timeout_hit;

`ifdef SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE)     cnt_d = '0;
    else if (state_q == WAIT) cnt_d = cnt_q + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign timeout_hit    = 1'b0;
`endif

  // Two-pass scan: first requester at or above ptr, otherwise the lowest one (wrap-around).
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j] && (IDW'(j) >= ptr_q)) begin
        found = 1'b1;
        win   = IDW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!found && req[j]) begin
        found = 1'b1;
        win   = IDW'(j);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    sel_d = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (win == IDW'(j)) begin
        sel_a = op_a[j*WIDTH +: WIDTH];
        sel_b = op_b[j*WIDTH +: WIDTH];
        sel_c = op_c[j*WIDTH +: WIDTH];
        sel_d = op_d[j*WIDTH +: WIDTH];
      end
    end
  end

  assign ptr_nxt = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    eng_a_d     = eng_a_q;
    eng_b_d     = eng_b_q;
    eng_c_d     = eng_c_q;
    eng_d_d     = eng_d_q;
    res_d       = res_q;
    res_id_d    = res_id_q;
    res_valid_d = 1'b0;
    err_d       = 1'b0;
    gnt         = '0;
    eng_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          for (int j = 0; j < NREQ; j++) gnt[j] = (win == IDW'(j));
          eng_a_d = sel_a;
          eng_b_d = sel_b;
          eng_c_d = sel_c;
          eng_d_d = sel_d;
          id_d    = win;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        eng_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (eng_valid) begin
          res_d       = eng_f;
          res_id_d    = id_q;
          res_valid_d = 1'b1;
          ptr_d       = ptr_nxt;
          state_d     = IDLE;
        end else if (timeout_hit) begin
          res_d       = '0;
          res_id_d    = id_q;
          res_valid_d = 1'b1;
          err_d       = 1'b1;
          ptr_d       = ptr_nxt;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      eng_a_q     <= '0;
      eng_b_q     <= '0;
      eng_c_q     <= '0;
      eng_d_q     <= '0;
      res_q       <= '0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      eng_a_q     <= eng_a_d;
      eng_b_q     <= eng_b_d;
      eng_c_q     <= eng_c_d;
      eng_d_q     <= eng_d_d;
      res_q       <= res_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign eng_a     = eng_a_q;
  assign eng_b     = eng_b_q;
  assign eng_c     = eng_c_q;
  assign eng_d     = eng_d_q;
  assign res       = res_q;
  assign res_id    = res_id_q;
  assign res_valid = res_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sum4_rr_sched.sv
// Directed bench for sum4_rr_sched with an engine model (valid 6 cycles after start) and a result scoreboard.
module tb_sum4_rr_sched;
  localparam int W   = 4;
  localparam int N   = 3;
  localparam int IDW = 2;
  localparam int TO  = 15;
  localparam int RW  = W + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req = '0;
  logic [W-1:0]   a_v[N], b_v[N], c_v[N], d_v[N];
  logic [N*W-1:0] op_a, op_b, op_c, op_d;
  logic [N-1:0]   gnt;
  logic           busy, res_valid, err, eng_start, eng_valid;
  logic [RW-1:0]  res, eng_f;
  logic [IDW-1:0] res_id;
  logic [W-1:0]   eng_a, eng_b, eng_c, eng_d;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      op_a[i*W +: W] = a_v[i];
      op_b[i*W +: W] = b_v[i];
      op_c[i*W +: W] = c_v[i];
      op_d[i*W +: W] = d_v[i];
    end
  end

  sum4_rr_sched #(.WIDTH(W), .NREQ(N), .IDW(IDW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
    .gnt(gnt), .busy(busy), .res(res), .res_id(res_id), .res_valid(res_valid), .err(err),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b), .eng_c(eng_c), .eng_d(eng_d),
    .eng_f(eng_f), .eng_valid(eng_valid)
  );

  // Engine model: result-valid six cycles after the start pulse; can be made silent.
  logic [5:0] sr;
  logic       eng_dead = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[4:0], eng_start};
  end
  assign eng_valid = sr[5] && !eng_dead;
  assign eng_f     = eng_valid ? (RW'(eng_a) + RW'(eng_b) + RW'(eng_c) + RW'(eng_d)) : '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [RW-1:0]  res;
    logic [IDW-1:0] id;
    logic           err;
    int             cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int   ptr_m = 0;
  int   gw, gk;
  int   gcyc[$];
  logic [N-1:0] gid[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbiter: predicts the winner and pushes the expected result at grant time.
  always @(negedge clk) begin
    if (rst_n && gnt != '0) begin
      gw = -1;
      for (int i = 0; i < N; i++) begin
        gk = (ptr_m + i) % N;
        if (gw < 0 && req[gk]) gw = gk;
      end
      check("gnt_winner", 32'(gnt), (gw < 0) ? 32'd0 : (32'd1 << gw));
      if (gw >= 0) begin
        e.id  = IDW'(gw);
        e.err = eng_dead;
        e.res = eng_dead ? '0 : RW'(a_v[gw]) + RW'(b_v[gw]) + RW'(c_v[gw]) + RW'(d_v[gw]);
        e.cyc = eng_dead ? cyc + 2 + TO : cyc + 8;
        sb.push_back(e);
        ptr_m = (gw + 1) % N;
        gcyc.push_back(cyc);
        gid.push_back(gnt);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (sb.size() == 0) begin
        check("res_valid_unexpected", 32'(res_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("res",       32'(res),    32'(e.res));
        check("res_id",    32'(res_id), 32'(e.id));
        check("err",       32'(err),    32'(e.err));
        check("res_cycle", cyc,         e.cyc);
      end
    end
    if (rst_n && err && !res_valid) check("err_orphan", 32'(err), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string p);
    check({p, "_busy"},      32'(busy),      32'd0);
    check({p, "_gnt"},       32'(gnt),       32'd0);
    check({p, "_eng_start"}, 32'(eng_start), 32'd0);
    check({p, "_eng_ops"},   32'({eng_a, eng_b, eng_c, eng_d}), 32'd0);
    check({p, "_res"},       32'(res),       32'd0);
    check({p, "_res_id"},    32'(res_id),    32'd0);
    check({p, "_res_valid"}, 32'(res_valid), 32'd0);
    check({p, "_err"},       32'(err),       32'd0);
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < lim) begin
      @(posedge clk);
      #2;
      n++;
    end
    check({tag, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic set_ops(input int k, input int a, input int b, input int c, input int d);
    a_v[k] = W'(a);
    b_v[k] = W'(b);
    c_v[k] = W'(c);
    d_v[k] = W'(d);
  endtask

  initial begin
    for (int i = 0; i < N; i++) set_ops(i, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    reset_checks("rst");
    tick();
    rst_n = 1'b1;
    tick();

    // Round-robin with all requests held: 0,1,2,0, back-to-back every 8 cycles.
    set_ops(0, 1, 1, 1, 1);
    set_ops(1, 2, 3, 4, 5);
    set_ops(2, 7, 8, 9, 10);
    req = 3'b111;
    for (int i = 0; i < 80 && gcyc.size() < 4; i++) begin
      @(posedge clk);
      #2;
    end
    req = '0;
    check("rr_grants", 32'(gcyc.size()), 32'd4);
    if (gcyc.size() == 4) begin
      check("rr_order0", 32'(gid[0]), 32'b001);
      check("rr_order1", 32'(gid[1]), 32'b010);
      check("rr_order2", 32'(gid[2]), 32'b100);
      check("rr_order3", 32'(gid[3]), 32'b001);
      for (int i = 0; i < 3; i++) check("rr_spacing", gcyc[i+1] - gcyc[i], 8);
    end
    wait_done("rr", 40);

    // Single request: 1+2+3+4.
    tick();
    set_ops(0, 1, 2, 3, 4);
    req = 3'b001;
    @(negedge clk);
    check("s1_gnt", 32'(gnt), 32'b001);
    check("s1_busy_at_gnt", 32'(busy), 32'd0);
    tick();
    req = '0;
    @(negedge clk);
    check("s1_eng_start", 32'(eng_start), 32'd1);
    check("s1_busy", 32'(busy), 32'd1);
    wait_done("s1", 40);
    check("s1_res_hold", 32'(res), 32'd10);

    // Maximum operands.
    tick();
    set_ops(0, 15, 15, 15, 15);
    req = 3'b001;
    @(negedge clk);
    check("ovf_gnt", 32'(gnt), 32'b001);
    tick();
    req = '0;
    wait_done("ovf", 40);
    check("ovf_res_hold", 32'(res), 32'h3c);

    // Operand change after grant must not reach the engine.
    tick();
    set_ops(1, 1, 5, 2, 3);
    req = 3'b010;
    @(negedge clk);
    check("stab_gnt", 32'(gnt), 32'b010);
    tick();
    b_v[1] = 4'd9;
    req = '0;
    repeat (6) begin
      @(negedge clk);
      check("stab_eng_b", 32'(eng_b), 32'd5);
    end
    wait_done("stab", 40);

    // Reset in the middle of WAIT.
    tick();
    set_ops(0, 3, 3, 3, 3);
    req = 3'b001;
    @(negedge clk);
    check("mrst_gnt", 32'(gnt), 32'b001);
    tick();
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    ptr_m = 0;
    @(negedge clk);
    reset_checks("mrst");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("mrst_no_res", 32'(res_valid), 32'd0);
    set_ops(1, 4, 4, 4, 4);
    set_ops(2, 5, 5, 5, 5);
    req = 3'b110;
    @(negedge clk);
    check("mrst_gnt_after", 32'(gnt), 32'b010);
    tick();
    req = '0;
    wait_done("mrst", 40);

`ifdef SCHED_TIMEOUT_EN
    // Silent engine: watchdog abort, then normal service.
    tick();
    eng_dead = 1'b1;
    set_ops(2, 1, 1, 1, 1);
    req = 3'b100;
    @(negedge clk);
    check("to_gnt", 32'(gnt), 32'b100);
    tick();
    req = '0;
    wait_done("to", TO + 20);
    eng_dead = 1'b0;
    tick();
    set_ops(0, 2, 2, 2, 2);
    req = 3'b001;
    @(negedge clk);
    check("to_next_gnt", 32'(gnt), 32'b001);
    tick();
    req = '0;
    wait_done("to_next", 40);
`endif

    repeat (3) tick();
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sum4_rr_sched.md
Name: sum4_rr_sched

Overview:
Round-robin scheduler that shares one sequential 4-operand accumulate engine among NREQ requesters. It arbitrates requests and latches the winner's operands. It then drives the engine's start/operand inputs, waits for the engine's valid, and returns the sum tagged with the requester id. It sits between client blocks and the single engine instance, so no client talks to the engine directly.

Parameters:
WIDTH, 4, operand width; result width is WIDTH+2
NREQ, 3, number of requesters (2..8)
IDW, 2, requester id width; must satisfy 2^IDW >= NREQ
TIMEOUT, 15, watchdog limit in cycles (used only with SCHED_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
req  in  NREQ  per-requester request level
op_a  in  NREQ*WIDTH  operand A per requester, slice i = [i*WIDTH +: WIDTH]
op_b  in  NREQ*WIDTH  operand B, same packing
op_c  in  NREQ*WIDTH  operand C, same packing
op_d  in  NREQ*WIDTH  operand D, same packing
gnt  out  NREQ  one-hot, one-cycle grant pulse; operands sampled this cycle
busy  out  1  high whenever FSM is not IDLE
res  out  WIDTH+2  A+B+C+D of the served requester
res_id  out  IDW  index of the served requester
res_valid  out  1  one-cycle pulse; res/res_id valid
err  out  1  pulse alongside res_valid on watchdog abort (tied 0 without macro)
eng_start  out  1  start pulse to engine
eng_a, eng_b, eng_c, eng_d  out  WIDTH each  engine operands
eng_f  in  WIDTH+2  engine result
eng_valid  in  1  engine result-valid pulse

Behaviour:
- Reset (async): state=IDLE, ptr=0, gnt=0, eng_start=0, eng_a..d=0, res=0, res_id=0, res_valid=0, err=0, busy=0.
- Arbitration: round-robin from priority pointer ptr. Search req[ptr], req[ptr+1], ... mod NREQ; first set bit wins. After a request is served by id k, ptr <= (k+1) mod NREQ. Reset gives priority order 0,1,2.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any req bit is set, assert gnt[win] combinationally this cycle. Latch that requester's op_a..d into eng_a..d and its id into an internal id register, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: eng_start=1 for exactly this cycle, then go to WAIT.
- WAIT: on eng_valid, register res<=eng_f, res_id<=id, res_valid<=1 (visible next cycle), update ptr, and go to IDLE. eng_valid arriving in any other state is ignored.
- eng_a..d are held constant from the grant cycle until the FSM leaves WAIT; the engine reads operands across several cycles.
- Requester handshake: a requester holds req and operands stable until it sees its gnt. It may change operands or drop req afterwards. A req still high after service counts as a new request and competes under round-robin.
- Latency with the current engine (eng_valid 6 cycles after eng_start): gnt at cycle 0, eng_start at cycle 1, eng_valid at cycle 7, res_valid at cycle 8.
- Back-to-back: IDLE may issue the next gnt in the same cycle res_valid is high. Throughput is one operation per 8 cycles.
- Width: res is WIDTH+2 bits, so the maximum sum 4*(2^WIDTH-1) never overflows.
- Reset mid-operation: all state is cleared. No res_valid is produced for the aborted operation; ptr returns to 0.

Optional Feature:
SCHED_TIMEOUT_EN
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. If it reaches TIMEOUT without eng_valid, the block pulses res_valid with err=1, res=0 and res_id=id, updates ptr, and returns to IDLE.
- Undefined: no counter; WAIT persists until eng_valid; err is tied 0.

Test Plan:
- Single request (WIDTH=4): req=3'b001, A=1, B=2, C=3, D=4 -> gnt=001 at cycle 0; eng_start at cycle 1; res=10, res_id=0, res_valid at cycle 8; err=0.
- Overflow width: req0 with A=B=C=D=4'hF -> res=6'h3C.
- Round-robin: req=3'b111 held continuously -> grants in order 0,1,2,0; each result tagged with the matching res_id; next gnt in the same cycle as the previous res_valid.
- Operand stability: req1 is granted, then op_b slice 1 changes from 5 to 9 one cycle after gnt -> result uses 5; eng_b stays constant through WAIT.
- Reset mid-WAIT: assert rst_n low at cycle 4 of an operation -> all outputs return to reset values; no res_valid; after release, req=3'b110 grants id 1 first (ptr=0).
- With SCHED_TIMEOUT_EN and the engine model never asserting eng_valid: res_valid=1, err=1, res=0 exactly TIMEOUT cycles after entering WAIT; the next request is granted normally.
